// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view. The master modport is the requester/SRAM-model view.
interface sram_arbiter_if;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [1:0]    a_be;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [1:0]    b_be;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_in;
    logic [DW-1:0] sram_dq_out;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;
    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_be,
        input  b_req, b_we, b_addr, b_wdata, b_be,
        input  sram_dq_in,
        output a_ack, a_rdata, b_ack, b_rdata,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_be,
        output b_req, b_we, b_addr, b_wdata, b_be,
        output sram_dq_in,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between two requesters.
// All SRAM strobes and port outputs are registered. They are computed from the next state.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    sram_arbiter_if.slave   bus
);
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;

    state_t           r_state,  w_state;
    logic             r_last_b, w_last_b;
    logic [CNT_W-1:0] r_cnt,    w_cnt;
    logic             r_we,     w_we;
    logic [1:0]       r_be,     w_be;
    logic [AW-1:0]    r_addr,   w_addr;
    logic [DW-1:0]    r_dq_out, w_dq_out;
    logic             r_dq_oe,  w_dq_oe;
    logic             r_ce_n,   w_ce_n;
    logic             r_oe_n,   w_oe_n;
    logic             r_we_n,   w_we_n;
    logic             r_ub_n,   w_ub_n;
    logic             r_lb_n,   w_lb_n;
    logic             r_a_ack,  w_a_ack;
    logic             r_b_ack,  w_b_ack;
    logic [DW-1:0]    r_a_rdata, w_a_rdata;
    logic [DW-1:0]    r_b_rdata, w_b_rdata;
    logic             r_busy,   w_busy;
    logic             w_grant;

    // Next state, latched operands and next-cycle strobe values
    always_comb begin
        w_state   = r_state;
        w_last_b  = r_last_b;
        w_cnt     = r_cnt;
        w_we      = r_we;
        w_be      = r_be;
        w_addr    = r_addr;
        w_dq_out  = r_dq_out;
        w_a_rdata = r_a_rdata;
        w_b_rdata = r_b_rdata;
        w_a_ack   = 1'b0;
        w_b_ack   = 1'b0;
        w_dq_oe   = 1'b0;
        w_ce_n    = 1'b1;
        w_oe_n    = 1'b1;
        w_we_n    = 1'b1;
        w_ub_n    = 1'b1;
        w_lb_n    = 1'b1;
        w_grant   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.a_req && (!bus.b_req || r_last_b)) begin
                    w_grant  = 1'b1;
                    w_last_b = 1'b0;
                    w_we     = bus.a_we;
                    w_be     = bus.a_be;
                    w_addr   = bus.a_addr;
                    w_dq_out = bus.a_we ? bus.a_wdata : r_dq_out;
                end else if (bus.b_req) begin
                    w_grant  = 1'b1;
                    w_last_b = 1'b1;
                    w_we     = bus.b_we;
                    w_be     = bus.b_be;
                    w_addr   = bus.b_addr;
                    w_dq_out = bus.b_we ? bus.b_wdata : r_dq_out;
                end
                if (w_grant) begin
                    w_cnt   = CNT_W'(ACCESS_CYCLES - 1);
                    w_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state = ST_ACK;
                    w_dq_oe = r_we;
                    if (r_last_b) begin
                        w_b_ack = 1'b1;
                        if (!r_we) w_b_rdata = bus.sram_dq_in;
                    end else begin
                        w_a_ack = 1'b1;
                        if (!r_we) w_a_rdata = bus.sram_dq_in;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACK:  w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase

        // Strobes follow the latched operands for every cycle spent in ACCESS
        if (w_state == ST_ACCESS) begin
            w_ce_n  = 1'b0;
            w_oe_n  = w_we;
            w_we_n  = ~w_we;
            w_ub_n  = ~w_be[1];
            w_lb_n  = ~w_be[0];
            w_dq_oe = w_we;
        end

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_last_b  <= 1'b1;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_dq_out  <= '0;
            r_dq_oe   <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_lb_n    <= 1'b1;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_last_b  <= w_last_b;
            r_cnt     <= w_cnt;
            r_we      <= w_we;
            r_be      <= w_be;
            r_addr    <= w_addr;
            r_dq_out  <= w_dq_out;
            r_dq_oe   <= w_dq_oe;
            r_ce_n    <= w_ce_n;
            r_oe_n    <= w_oe_n;
            r_we_n    <= w_we_n;
            r_ub_n    <= w_ub_n;
            r_lb_n    <= w_lb_n;
            r_a_ack   <= w_a_ack;
            r_b_ack   <= w_b_ack;
            r_a_rdata <= w_a_rdata;
            r_b_rdata <= w_b_rdata;
            r_busy    <= w_busy;
        end
    end

    assign bus.a_ack       = r_a_ack;
    assign bus.b_ack       = r_b_ack;
    assign bus.a_rdata     = r_a_rdata;
    assign bus.b_rdata     = r_b_rdata;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_ub_n   = r_ub_n;
    assign bus.sram_lb_n   = r_lb_n;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with ACCESS_CYCLES=2 and one with 15.
// A free-running checker watches the bus invariants on both instances.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    sram_arbiter_if bif();
    sram_arbiter_if bif15();

    sram_arbiter #(.ACCESS_CYCLES(2))  u_dut   (.clk(clk), .reset(rst), .bus(bif.slave));
    sram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (.clk(clk), .reset(rst), .bus(bif15.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ticks until either ack of the ACCESS_CYCLES=2 instance; port=-1 if the budget runs out
    task automatic wait_ack(input int limit, output int port, output int at);
        port = -1;
        for (int i = 0; i < limit && port < 0; i++) begin
            tick();
            if (bif.a_ack)      port = 0;
            else if (bif.b_ack) port = 1;
        end
        at = cyc;
    endtask

    // Bus invariants: single ack, no read/write strobe overlap, data driven only for a write
    logic prev_we_n   = 1'b1;
    logic prev_we_n15 = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            prev_we_n   = 1'b1;
            prev_we_n15 = 1'b1;
        end else begin
            chk("inv_two_acks", 32'(bif.a_ack & bif.b_ack), 32'd0);
            chk("inv_we_oe_low", 32'(!bif.sram_we_n && !bif.sram_oe_n), 32'd0);
            chk("inv_dq_oe", 32'(bif.sram_dq_oe &&
                !(!bif.sram_we_n || ((bif.a_ack || bif.b_ack) && !prev_we_n))), 32'd0);
            chk("inv15_two_acks", 32'(bif15.a_ack & bif15.b_ack), 32'd0);
            chk("inv15_we_oe_low", 32'(!bif15.sram_we_n && !bif15.sram_oe_n), 32'd0);
            chk("inv15_dq_oe", 32'(bif15.sram_dq_oe &&
                !(!bif15.sram_we_n || ((bif15.a_ack || bif15.b_ack) && !prev_we_n15))), 32'd0);
            prev_we_n   = bif.sram_we_n;
            prev_we_n15 = bif15.sram_we_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int port, at, at0, k, seen;

        rst = 1'b1;
        bif.a_req = 1'b0;   bif.a_we = 1'b0;   bif.a_addr = '0; bif.a_wdata = '0; bif.a_be = '0;
        bif.b_req = 1'b0;   bif.b_we = 1'b0;   bif.b_addr = '0; bif.b_wdata = '0; bif.b_be = '0;
        bif.sram_dq_in = '0;
        bif15.a_req = 1'b0; bif15.a_we = 1'b0; bif15.a_addr = '0; bif15.a_wdata = '0; bif15.a_be = '0;
        bif15.b_req = 1'b0; bif15.b_we = 1'b0; bif15.b_addr = '0; bif15.b_wdata = '0; bif15.b_be = '0;
        bif15.sram_dq_in = '0;

        // Reset values, before any clock edge
        #2;
        chk("rst_strobes", 32'({bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_ub_n, bif.sram_lb_n}), 32'h1F);
        chk("rst_dq_oe", 32'(bif.sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(bif.sram_addr), 32'd0);
        chk("rst_dq_out", 32'(bif.sram_dq_out), 32'd0);
        chk("rst_acks", 32'({bif.a_ack, bif.b_ack}), 32'd0);
        chk("rst_rdata", 32'({bif.a_rdata, bif.b_rdata}), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(bif.busy), 32'd0);
        chk("idle_ce_n", 32'(bif.sram_ce_n), 32'd1);

        // Single read on A
        bif.a_req = 1'b1; bif.a_we = 1'b0; bif.a_addr = 20'h00010; bif.a_be = 2'b11;
        bif.sram_dq_in = 16'hBEEF;
        tick();
        chk("rd1_strobes", 32'({bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_dq_oe}), 32'b0010);
        chk("rd1_addr", 32'(bif.sram_addr), 32'h10);
        chk("rd1_busy", 32'(bif.busy), 32'd1);
        chk("rd1_ack_early", 32'(bif.a_ack), 32'd0);
        tick();
        chk("rd2_oe_n", 32'(bif.sram_oe_n), 32'd0);
        chk("rd2_ack_early", 32'(bif.a_ack), 32'd0);
        tick();
        chk("rd_ack", 32'({bif.a_ack, bif.b_ack}), 32'b10);
        chk("rd_ack_strobes", 32'({bif.sram_ce_n, bif.sram_oe_n}), 32'b11);
        chk("rd_rdata", 32'(bif.a_rdata), 32'hBEEF);
        bif.a_req = 1'b0;
        tick();
        chk("rd_after_ack", 32'(bif.a_ack), 32'd0);
        chk("rd_after_busy", 32'(bif.busy), 32'd0);

        // Single write on B, lower byte only
        bif.b_req = 1'b1; bif.b_we = 1'b1; bif.b_addr = 20'h00020; bif.b_wdata = 16'h1234; bif.b_be = 2'b01;
        bif.sram_dq_in = 16'hDEAD;
        tick();
        chk("wr1_strobes", 32'({bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_ub_n, bif.sram_lb_n, bif.sram_dq_oe}), 32'b010101);
        chk("wr1_dq_out", 32'(bif.sram_dq_out), 32'h1234);
        chk("wr1_addr", 32'(bif.sram_addr), 32'h20);
        tick();
        chk("wr2_we_n", 32'(bif.sram_we_n), 32'd0);
        chk("wr2_ack_early", 32'(bif.b_ack), 32'd0);
        tick();
        chk("wr_ack", 32'({bif.a_ack, bif.b_ack}), 32'b01);
        chk("wr_ack_strobes", 32'({bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_ub_n, bif.sram_lb_n, bif.sram_dq_oe}), 32'b111111);
        chk("wr_hold_dq_out", 32'(bif.sram_dq_out), 32'h1234);
        chk("wr_b_rdata", 32'(bif.b_rdata), 32'd0);
        chk("wr_a_rdata", 32'(bif.a_rdata), 32'hBEEF);
        bif.b_req = 1'b0;
        tick();
        chk("wr_after_dq_oe", 32'(bif.sram_dq_oe), 32'd0);
        chk("wr_after_ack", 32'(bif.b_ack), 32'd0);

        // Tie straight after reset: A first, B four cycles later
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.a_req = 1'b1; bif.a_we = 1'b0; bif.a_addr = 20'h00100; bif.a_be = 2'b11;
        bif.b_req = 1'b1; bif.b_we = 1'b0; bif.b_addr = 20'h00200; bif.b_be = 2'b11;
        bif.sram_dq_in = 16'h5555;
        k = cyc;
        wait_ack(6, port, at0);
        chk("tie_first_port", 32'(port), 32'd0);
        chk("tie_first_lat", 32'(at0 - k), 32'd3);
        bif.a_req = 1'b0;
        wait_ack(6, port, at);
        chk("tie_second_port", 32'(port), 32'd1);
        chk("tie_interval", 32'(at - at0), 32'd4);
        bif.b_req = 1'b0;
        tick();

        // Sustained contention: grants alternate starting with A
        bif.a_req = 1'b1;
        bif.b_req = 1'b1;
        at0 = 0;
        for (int n = 0; n < 6; n++) begin
            wait_ack(6, port, at);
            chk("rr_port", 32'(port), 32'(n % 2));
            if (n > 0) chk("rr_interval", 32'(at - at0), 32'd4);
            at0 = at;
        end
        bif.a_req = 1'b0;
        bif.b_req = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a write
        bif.a_req = 1'b1; bif.a_we = 1'b1; bif.a_addr = 20'h00030; bif.a_wdata = 16'hAAAA; bif.a_be = 2'b11;
        tick();
        tick();
        chk("rstw_pre_we_n", 32'(bif.sram_we_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_we_n", 32'(bif.sram_we_n), 32'd1);
        chk("rstw_dq_oe", 32'(bif.sram_dq_oe), 32'd0);
        chk("rstw_busy", 32'(bif.busy), 32'd0);
        chk("rstw_ce_n", 32'(bif.sram_ce_n), 32'd1);
        chk("rstw_a_rdata", 32'(bif.a_rdata), 32'd0);
        bif.a_req = 1'b0;
        bif.a_we  = 1'b0;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bif.a_ack || bif.b_ack || bif.busy) seen = 1;
        end
        chk("rstw_no_ack", 32'(seen), 32'd0);

        // Longest access: ack 16 cycles after the grant cycle
        bif15.a_req = 1'b1; bif15.a_we = 1'b0; bif15.a_addr = 20'h003FF; bif15.a_be = 2'b11;
        bif15.sram_dq_in = 16'hCAFE;
        k  = cyc;
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            tick();
            if (bif15.a_ack) at = cyc;
        end
        chk("max_latency", 32'(at - k), 32'd16);
        chk("max_rdata", 32'(bif15.a_rdata), 32'hCAFE);
        bif15.a_req = 1'b0;
        tick();
        chk("max_ack_once", 32'(bif15.a_ack), 32'd0);

        // Interleaved reads; operand changes after grant are ignored
        bif.a_req = 1'b1; bif.a_we = 1'b0; bif.a_addr = 20'h00040; bif.a_be = 2'b11;
        bif.sram_dq_in = 16'h1111;
        tick();
        bif.a_addr = 20'h00099;
        bif.a_we   = 1'b1;
        tick();
        chk("il_addr_held", 32'(bif.sram_addr), 32'h40);
        chk("il_read_held", 32'({bif.sram_oe_n, bif.sram_we_n}), 32'b01);
        tick();
        chk("il_a_ack", 32'(bif.a_ack), 32'd1);
        chk("il_a_rdata", 32'(bif.a_rdata), 32'h1111);
        bif.a_req = 1'b0;
        bif.a_we  = 1'b0;
        tick();
        bif.b_req = 1'b1; bif.b_we = 1'b0; bif.b_addr = 20'h00050; bif.b_be = 2'b10;
        bif.sram_dq_in = 16'h2222;
        tick();
        chk("il_b_bytes", 32'({bif.sram_ub_n, bif.sram_lb_n}), 32'b01);
        // A request that comes and goes while B is busy must never be served
        bif.a_req = 1'b1;
        wait_ack(6, port, at);
        chk("il_b_port", 32'(port), 32'd1);
        chk("il_b_rdata", 32'(bif.b_rdata), 32'h2222);
        chk("il_a_unchanged", 32'(bif.a_rdata), 32'h1111);
        bif.a_req = 1'b0;
        bif.b_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bif.a_ack || bif.busy) seen = 1;
        end
        chk("dropped_req_no_access", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SRAM strobe-active cycles per access (legal 1..15).
REQ-002 clk  input  1  system clock (50 MHz domain).
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_req / b_req  input  1 each  access request, port A (audio playback) / port B (decoder).
REQ-005 a_we / b_we  input  1 each  1 = write, 0 = read.
REQ-006 a_addr / b_addr  input  20 each  SRAM word address.
REQ-007 a_wdata / b_wdata  input  16 each  write data.
REQ-008 a_be / b_be  input  2 each  byte enables, active-high; bit1 = upper byte, bit0 = lower byte.
REQ-009 a_ack / b_ack  output  1 each  one-cycle completion pulse.
REQ-010 a_rdata / b_rdata  output  16 each  read data, valid from the ack cycle and held until the port's next read completes.
REQ-011 sram_addr  output  20  SRAM address.
REQ-012 sram_dq_in  input  16; sram_dq_out  output  16; sram_dq_oe  output  1  split tristate data bus (top level merges these into the inout).
REQ-013 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, ACK; all outputs registered.
REQ-016 IDLE: req inputs sampled only here; if neither port requests, stay in IDLE with all strobes high and sram_dq_oe=0.
REQ-017 IDLE, one port requesting: grant it; if both request, grant the port not in last_grant (round-robin).
REQ-018 On grant: latch the granted port's we/addr/wdata/be; update last_grant; load the counter with ACCESS_CYCLES-1; go to ACCESS.
REQ-019 ACCESS strobes: sram_addr = latched addr; ce_n=0; ub_n=~be[1]; lb_n=~be[0].
REQ-020 ACCESS read: oe_n=0, we_n=1, dq_oe=0.
REQ-021 ACCESS write: we_n=0, oe_n=1, dq_oe=1, dq_out = latched wdata.
REQ-022 ACCESS counter: decrement each cycle; on the cycle the counter is 0, a read captures sram_dq_in into the granted port's rdata; then go to ACK.
REQ-023 ACK: ce_n=oe_n=we_n=ub_n=lb_n=1; the granted port's ack=1 for exactly this cycle.
REQ-024 ACK, write: dq_oe stays 1 and dq_out stays valid through this cycle (data hold); dq_oe=0 on return to IDLE.
REQ-025 ACK always returns to IDLE.
REQ-026 Latency: req high in IDLE cycle k; ACCESS in cycles k+1..k+ACCESS_CYCLES; ack in cycle k+ACCESS_CYCLES+1.
REQ-027 Throughput: back-to-back issue interval is ACCESS_CYCLES+2 cycles.
REQ-028 Requester protocol: hold req and operands stable until ack; deassert req in the cycle after ack.
REQ-029 req still high during ACK is ignored; req high in the following IDLE cycle is a new request.
REQ-030 Port inputs changing after grant have no effect on the access in progress.
REQ-031 req dropped before grant: no access is issued for that port.
REQ-032 Never both acks in the same cycle; never two grants outstanding.
REQ-033 Never we_n=0 and oe_n=0 together.
REQ-034 dq_oe=1 only while a write is granted.
REQ-035 a_rdata and b_rdata update only on their own port's read completion; writes and the other port leave them unchanged.

Reset
REQ-036 reset=1 forces immediately, independent of clk: state=IDLE; last_grant=B (so port A wins the first tie); counter=0.
REQ-037 reset=1 also forces immediately: ce_n=oe_n=we_n=ub_n=lb_n=1; dq_oe=0; sram_addr=0; dq_out=0; a_ack=b_ack=0; a_rdata=b_rdata=0; busy=0.
REQ-038 reset asserted mid-ACCESS aborts the access with no ack; the interrupted request must be reissued.
REQ-039 First request is sampled on the first rising edge after reset deasserts.

Verification
REQ-040 Single read (ACCESS_CYCLES=2): A read addr 0x00010, sram_dq_in=0xBEEF -> oe_n low 2 cycles, a_ack at k+3, a_rdata=0xBEEF.
REQ-041 Single write: B write 0x00020, data 0x1234, be=2'b01 -> we_n low 2 cycles, ub_n=1, lb_n=0, dq_out=0x1234 with dq_oe=1 through ACK, b_ack once.
REQ-042 Tie after reset: A and B request the same cycle -> A served first, B next, ack interval 4 cycles.
REQ-043 Sustained contention: A and B held continuously for 6 accesses -> grants alternate A,B,A,B,A,B.
REQ-044 Reset mid-write: reset during the 2nd ACCESS cycle -> we_n=1 and dq_oe=0 at once, no ack, busy=0.
REQ-045 Max-parameter read: ACCESS_CYCLES=15 -> ack exactly 16 cycles after grant.
REQ-046 Interleaved reads: A read, then B read -> a_rdata unchanged after B's read.
REQ-047 All scenarios: assertions continuously check REQ-032, REQ-033 and REQ-034.
